display_sequencer: RTL and testbench
====================================

Name: display_sequencer

Overview:
- Sequences a bank of NUM_DIGITS 5-bit display codes; each code drives one external 7-segment decoder instance.
- Plays a display effect on request: static load, spinner using the ring-segment codes 5'h10..5'h15, right-to-left scroll-in, or blink. Then settles on the requested value.
- Sits between game/control logic and the per-digit decoders.
- Per-digit enables implement blanking, because every 5-bit code lights at least one segment.

Parameters:
- NUM_DIGITS, 4, number of digits; digit 0 is rightmost and maps to codes[4:0].
- TICK_DIV, 12500000, clock cycles per animation step; must be at least 2.
- SPIN_ROUNDS, 2, full ring rotations in SPIN mode.
- BLINKS, 3, off/on pairs in BLINK mode.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  2  0=STATIC, 1=SPIN, 2=SCROLL, 3=BLINK; sampled with start.
- value  in  5*NUM_DIGITS  final digit codes; latched on accept.
- abort  in  1  jump to final value immediately.
- codes  out  5*NUM_DIGITS  registered codes to the decoders.
- digit_en  out  NUM_DIGITS  registered per-digit enable; 0 = blank.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse, high only in FINISH.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE, codes=0, digit_en=0 (all blank), busy=0, done=0.
  - Tick counter and step counter cleared.
  - Applies from any state, including mid-animation.
- Accept: an edge with state=IDLE and start=1.
  - value is latched into val_q.
  - Tick counter is cleared, so the first tick occurs exactly TICK_DIV cycles after accept.
  - start in any other state is ignored.
  - Changes on value while busy are ignored.
- Tick: one-cycle pulse when the counter reaches TICK_DIV-1; the counter then wraps to 0. The counter is held at 0 in IDLE and FINISH.
- STATIC mode:
  - Accept edge: codes=value, digit_en=all 1, state goes to FINISH.
- SPIN mode:
  - Accept edge: every digit's code = 5'h10, digit_en=all 1, step k=0.
  - On tick: k=k+1.
  - If k < 6*SPIN_ROUNDS: every digit's code = 5'h10 + (k mod 6).
  - At k = 6*SPIN_ROUNDS: codes=val_q, state goes to FINISH.
- SCROLL mode:
  - Accept edge: codes=0, digit_en=all 0.
  - On tick j (j = 1..NUM_DIGITS):
    - codes shift one digit left;
    - digit 0 takes digit (NUM_DIGITS-j) of val_q;
    - digit_en shifts left with 1 shifted in.
  - After tick NUM_DIGITS: codes==val_q, digit_en=all 1, state goes to FINISH.
- BLINK mode:
  - Accept edge: codes=val_q, digit_en=all 1.
  - Each tick inverts all of digit_en.
  - After 2*BLINKS ticks digit_en is all 1; state goes to FINISH.
- abort=1 in SPIN, SCROLL or BLINK:
  - Next edge: codes=val_q, digit_en=all 1, state goes to FINISH.
  - abort has priority over a coincident tick.
  - abort is ignored in IDLE and FINISH.
- FINISH: lasts exactly one cycle with done=1 and busy=1; state then goes to IDLE unconditionally.
- Outputs in IDLE: codes and digit_en hold their last values.
- Counter widths: $clog2 of the maximum count. There is no overflow path.

Decomposition:
- Shared header/package:
  - mode encodings;
  - state encodings (IDLE, SPIN, SCROLL, BLINK, FINISH);
  - RING_BASE=5'h10 and RING_LEN=6.
- One sub-module, tick_divider:
  - parameter TICK_DIV;
  - inputs clock, reset, clear;
  - output tick.

Test Plan (NUM_DIGITS=4, TICK_DIV=4, SPIN_ROUNDS=1, BLINKS=2; value={5'h1,5'h2,5'h3,5'h4} with digit 3 first):
- Reset: hold reset=0 for 2 cycles -> codes=0, digit_en=0000, busy=0, done=0.
- STATIC: start with mode=0 -> next cycle codes=value, digit_en=1111, done=1 and busy=1 for one cycle -> then IDLE with busy=0.
- SPIN: start with mode=1 -> all digits 5'h10 from the cycle after accept; 5'h11 after 4 cycles, ..., 5'h15 after 20 cycles; codes=value at cycle 24, then a done pulse.
- SCROLL: start with mode=2 -> digit_en goes 0000, then 0001 (digit 0 = 5'h1), 0011, 0111, 1111 at 4-cycle spacing; final codes=value, then done.
- BLINK: start with mode=3 -> digit_en goes 1111, 0000, 1111, 0000, 1111 at ticks 0..4, then done; codes stay equal to value throughout.
- Boundaries:
  - start and value change during SPIN are ignored.
  - abort at cycle 10 of SPIN -> next cycle codes=value, then done.
  - reset=0 during SCROLL -> codes=0, digit_en=0000, IDLE.

Source files
------------

// File: rtl/display_sequencer_pkg.sv
// Shared encodings and constants for the display sequencer.
package display_sequencer_pkg;

    // Requested effect, as presented on the mode input
    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_SPIN   = 2'd1,
        MODE_SCROLL = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    // Sequencer states; STATIC needs no animation state and goes straight to FINISH
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPIN   = 3'd1,
        ST_SCROLL = 3'd2,
        ST_BLINK  = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    // Ring-segment codes used by the spinner: RING_BASE .. RING_BASE+RING_LEN-1
    localparam logic [4:0] RING_BASE = 5'h10;
    localparam int         RING_LEN  = 6;

    // Ring phase to decoder code
    function automatic logic [4:0] ring_code(input logic [2:0] phase);
        return RING_BASE + {2'b00, phase};
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Animation step generator: one-cycle tick every TICK_DIV cycles, held at phase 0 while cleared.
module tick_divider #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             last;

    assign last = (cnt == CNT_LAST);
    assign tick = last && !clear;

    // Free-running count that wraps on the last phase; clear restarts it from zero
    always_ff @(posedge clock) begin
        if (!reset || clear || last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/display_sequencer.sv
// Display effect sequencer: plays static/spin/scroll/blink on a bank of digit codes, then settles on the latched value.
module display_sequencer
    import display_sequencer_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 12500000,
    parameter int SPIN_ROUNDS = 2,
    parameter int BLINKS      = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [5*NUM_DIGITS-1:0] value,
    input  logic                    abort,
    output logic [5*NUM_DIGITS-1:0] codes,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    busy,
    output logic                    done
);

    localparam int CODES_W  = 5 * NUM_DIGITS;
    localparam int SPIN_N   = RING_LEN * SPIN_ROUNDS;
    localparam int BLINK_N  = 2 * BLINKS;
    localparam int MAX_A    = (SPIN_N > BLINK_N) ? SPIN_N : BLINK_N;
    localparam int STEP_MAX = (MAX_A > NUM_DIGITS) ? MAX_A : NUM_DIGITS;
    localparam int STEP_W   = $clog2(STEP_MAX + 1);

    localparam logic [STEP_W-1:0] SPIN_STEPS   = STEP_W'(SPIN_N);
    localparam logic [STEP_W-1:0] SCROLL_STEPS = STEP_W'(NUM_DIGITS);
    localparam logic [STEP_W-1:0] BLINK_STEPS  = STEP_W'(BLINK_N);
    localparam logic [2:0]        RING_LAST    = 3'(RING_LEN - 1);

    state_e                state_q, state_d;
    logic [CODES_W-1:0]    codes_q, codes_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic [CODES_W-1:0]    val_q, val_d;
    logic [STEP_W-1:0]     step_q, step_d, step_inc;
    logic [2:0]            ring_q, ring_d;
    logic [4:0]            scroll_digit;
    logic                  tick;
    int                    sel;

    // Counter restarts at every accept, so the first tick lands TICK_DIV cycles later
    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .clear ((state_q == ST_IDLE) || (state_q == ST_FINISH)),
        .tick  (tick)
    );

    assign codes    = codes_q;
    assign digit_en = en_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FINISH);

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            codes_q <= '0;
            en_q    <= '0;
            val_q   <= '0;
            step_q  <= '0;
            ring_q  <= '0;
        end else begin
            state_q <= state_d;
            codes_q <= codes_d;
            en_q    <= en_d;
            val_q   <= val_d;
            step_q  <= step_d;
            ring_q  <= ring_d;
        end
    end

    // Next state and next outputs; abort outranks a coincident tick
    always_comb begin
        state_d  = state_q;
        codes_d  = codes_q;
        en_d     = en_q;
        val_d    = val_q;
        step_d   = step_q;
        ring_d   = ring_q;
        step_inc = step_q + STEP_W'(1);
        // Scroll tick j = step+1 brings in digit NUM_DIGITS-j of the latched value
        sel          = NUM_DIGITS - 1 - int'(step_q);
        scroll_digit = val_q[sel*5 +: 5];

        if (state_q == ST_IDLE) begin
            if (start) begin
                val_d  = value;
                step_d = '0;
                ring_d = '0;
                case (mode_e'(mode))
                    MODE_STATIC: begin
                        codes_d = value;
                        en_d    = '1;
                        state_d = ST_FINISH;
                    end
                    MODE_SPIN: begin
                        codes_d = {NUM_DIGITS{RING_BASE}};
                        en_d    = '1;
                        state_d = ST_SPIN;
                    end
                    MODE_SCROLL: begin
                        codes_d = '0;
                        en_d    = '0;
                        state_d = ST_SCROLL;
                    end
                    default: begin
                        codes_d = value;
                        en_d    = '1;
                        state_d = ST_BLINK;
                    end
                endcase
            end
        end else if (state_q == ST_FINISH) begin
            state_d = ST_IDLE;
        end else if (abort) begin
            codes_d = val_q;
            en_d    = '1;
            state_d = ST_FINISH;
        end else if (tick) begin
            step_d = step_inc;
            case (state_q)
                ST_SPIN: begin
                    if (step_inc == SPIN_STEPS) begin
                        codes_d = val_q;
                        state_d = ST_FINISH;
                    end else begin
                        ring_d  = (ring_q == RING_LAST) ? 3'd0 : ring_q + 3'd1;
                        codes_d = {NUM_DIGITS{ring_code(ring_d)}};
                    end
                end
                ST_SCROLL: begin
                    codes_d = (codes_q << 5) | CODES_W'(scroll_digit);
                    en_d    = (en_q << 1) | NUM_DIGITS'(1);
                    if (step_inc == SCROLL_STEPS) state_d = ST_FINISH;
                end
                ST_BLINK: begin
                    en_d = ~en_q;
                    if (step_inc == BLINK_STEPS) state_d = ST_FINISH;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_sequencer.sv
// Directed bench for display_sequencer with small tick divider.
module tb_display_sequencer;

    localparam int N  = 4;
    localparam int TD = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [1:0]      mode;
    logic [5*N-1:0]  value;
    logic            abort;
    logic [5*N-1:0]  codes;
    logic [N-1:0]    digit_en;
    logic            busy;
    logic            done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5*N-1:0] vexp;
    logic [5*N-1:0] cexp;
    logic [N-1:0]   eexp;

    display_sequencer #(
        .NUM_DIGITS (N),
        .TICK_DIV   (TD),
        .SPIN_ROUNDS(1),
        .BLINKS     (2)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .value   (value),
        .abort   (abort),
        .codes   (codes),
        .digit_en(digit_en),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5*N-1:0] rep(input logic [4:0] c);
        return {N{c}};
    endfunction

    initial begin
        vexp  = {5'h1, 5'h2, 5'h3, 5'h4};
        reset = 1'b0;
        start = 1'b0;
        mode  = 2'd0;
        value = vexp;
        abort = 1'b0;

        // reset
        step(); step();
        chk("rst_codes", 32'(codes), 0);
        chk("rst_en", 32'(digit_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        reset = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 0);

        // STATIC
        start = 1'b1; mode = 2'd0;
        step();
        start = 1'b0;
        chk("st_codes", 32'(codes), 32'(vexp));
        chk("st_en", 32'(digit_en), 32'hF);
        chk("st_done", 32'(done), 1);
        chk("st_busy", 32'(busy), 1);
        step();
        chk("st_done_off", 32'(done), 0);
        chk("st_busy_off", 32'(busy), 0);
        chk("st_hold", 32'(codes), 32'(vexp));

        // SPIN, with start/value/mode changes ignored while busy
        start = 1'b1; mode = 2'd1;
        step();
        chk("sp_c0", 32'(codes), 32'(rep(5'h10)));
        chk("sp_en", 32'(digit_en), 32'hF);
        mode  = 2'd0;
        value = 20'hAAAAA;
        for (int c = 1; c <= 24; c++) begin
            if (c == 6) start = 1'b0;
            step();
            cexp = (c < 24) ? rep(5'(16 + c / 4)) : vexp;
            chk($sformatf("sp_c%0d", c), 32'(codes), 32'(cexp));
        end
        chk("sp_done", 32'(done), 1);
        value = vexp;
        step();
        chk("sp_idle", 32'(busy), 0);
        chk("sp_hold", 32'(codes), 32'(vexp));

        // SCROLL
        start = 1'b1; mode = 2'd2;
        step();
        start = 1'b0;
        chk("sc_c0", 32'(codes), 0);
        chk("sc_e0", 32'(digit_en), 0);
        for (int c = 1; c <= 16; c++) begin
            step();
            eexp = N'((1 << (c / 4)) - 1);
            cexp = vexp >> (5 * (N - c / 4));
            if (c / 4 == 0) cexp = '0;
            chk($sformatf("sc_e%0d", c), 32'(digit_en), 32'(eexp));
            chk($sformatf("sc_c%0d", c), 32'(codes), 32'(cexp));
        end
        chk("sc_done", 32'(done), 1);
        step();
        chk("sc_idle", 32'(busy), 0);

        // BLINK
        start = 1'b1; mode = 2'd3;
        step();
        start = 1'b0;
        chk("bl_e0", 32'(digit_en), 32'hF);
        for (int c = 1; c <= 16; c++) begin
            step();
            eexp = ((c / 4) % 2 == 1) ? 4'h0 : 4'hF;
            chk($sformatf("bl_e%0d", c), 32'(digit_en), 32'(eexp));
            chk($sformatf("bl_c%0d", c), 32'(codes), 32'(vexp));
        end
        chk("bl_done", 32'(done), 1);
        step();
        chk("bl_idle", 32'(busy), 0);

        // abort ignored in IDLE
        abort = 1'b1;
        step();
        chk("ab_idle", 32'(busy), 0);
        abort = 1'b0;

        // abort during SPIN at cycle 10
        start = 1'b1; mode = 2'd1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) step();
        chk("ab_c9", 32'(codes), 32'(rep(5'h12)));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_codes", 32'(codes), 32'(vexp));
        chk("ab_en", 32'(digit_en), 32'hF);
        chk("ab_done", 32'(done), 1);
        step();
        chk("ab_after", 32'(busy), 0);

        // reset during SCROLL
        start = 1'b1; mode = 2'd2;
        step();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) step();
        chk("rs_mid_en", 32'(digit_en), 32'h3);
        reset = 1'b0;
        step();
        chk("rs_codes", 32'(codes), 0);
        chk("rs_en", 32'(digit_en), 0);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_done", 32'(done), 0);
        reset = 1'b1;
        step();
        chk("rs_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
